stream_demux: RTL and testbench
===============================

// Module: stream_demux
// PURPOSE
//   1-to-N demultiplexer with a registered valid/ready handshake, the routing counterpart of the 2:1 mux.
//   One input stream carries packets; the in_sel value on a packet's first beat steers the whole packet to one output channel.
//   Sits between a single producer (DMA/bus side) and N consumer stages in the lab datapath.
// PARAMETERS
//   DATA_W  32  payload width per beat
//   N_OUT   3   number of output channels, >=2, need not be a power of 2
//   SEL_W   2   select width; must satisfy 2**SEL_W >= N_OUT
// PORTS
//   clk        in   1             single clock, all logic on rising edge
//   resetn     in   1             synchronous, active-low reset
//   in_valid   in   1             input beat valid
//   in_ready   out  1             input beat accepted when in_valid & in_ready
//   in_data    in   DATA_W        input payload
//   in_last    in   1             final beat of packet
//   in_sel     in   SEL_W         destination channel; sampled on first beat only
//   out_valid  out  N_OUT         per-channel beat valid
//   out_ready  in   N_OUT         per-channel consumer ready
//   out_data   out  N_OUT*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
//   out_last   out  N_OUT         per-channel last flag
//   sel_err    out  1             1-cycle pulse: packet first beat had in_sel >= N_OUT
// BEHAVIOUR
//   - Reset (resetn=0 at clk edge): out_valid=0, out_data=0, out_last=0, sel_err=0, FSM=IDLE.
//     Reset mid-packet discards buffered beats and lock state; no partial flush.
//   - FSM states:
//     IDLE: next beat is a first beat; target = in_sel.
//     FWD: target = latched sel.
//     DROP: packet is discarded.
//   - IDLE, accepted beat, in_sel < N_OUT: latch sel; go to FWD unless in_last (single-beat packet stays IDLE).
//   - IDLE, in_valid, in_sel >= N_OUT: in_ready=1; beat consumed, nothing forwarded; sel_err=1 next cycle;
//     go to DROP unless in_last.
//   - FWD/DROP: in_sel ignored; accepted beat with in_last returns FSM to IDLE.
//   - Each channel has a one-entry slot. Slot i is free when !out_valid[i] | out_ready[i].
//     in_ready = slot[target] free (FWD/IDLE-valid sel), or 1 (DROP / invalid sel). in_ready is combinational,
//     independent of in_valid.
//   - Latency: a beat accepted at edge k appears as out_valid[target]=1 after edge k; exactly one register stage.
//   - A slot accepts fill and drain in the same cycle: out_valid stays 1, data replaced, no bubble (full throughput per channel).
//   - Draining channel j never blocks input routed to channel i != j. Only one channel is filled per cycle.
//   - out_data/out_last hold their value while out_valid & !out_ready (AXI-style stability).
//   - Beat order within a channel is preserved; no reordering across packets.
// CONFIGURATION
//   STREAM_DEMUX_STATS_EN defined: adds output beat_cnt (N_OUT*16 bits). One 16-bit saturating counter per channel
//     increments on each out_valid&out_ready handshake, holds at 16'hFFFF, cleared by reset.
//   Not defined: port and counters absent; all other behaviour identical.
// STRUCTURE
//   - Shared header stream_demux_defs.vh: FSM state encodings (IDLE=2'd0, FWD=2'd1, DROP=2'd2), counter width 16.
//   - Sub-module demux_slot: one-entry valid/ready register (DATA_W+1 bits), instantiated N_OUT times via generate.
//   - Top holds FSM, sel latch, target decode, sel_err and optional stats.
// TESTING
//   - Reset: resetn=0 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, sel_err=0, no beat consumed into slots.
//   - Routing: 3-beat packet 0xA1,0xA2,0xA3 with sel=2 on first beat, sel=0 on later beats, all out_ready=1
//     -> all three on channel 2 only, 1-cycle latency, last on 0xA3.
//   - Backpressure: out_ready[1]=0 for 5 cycles with packet to ch1 -> first beat held stable, in_ready=0;
//     release -> beats delivered in order, no loss or duplication.
//   - Invalid select: first beat sel=3 (N_OUT=3), 2-beat packet -> both beats consumed, no out_valid, sel_err pulses once;
//     following packet sel=0 routes normally.
//   - Full throughput: ch0 out_ready=1, 8 back-to-back single-beat packets -> 8 beats in 8 consecutive cycles.
//     With STATS_EN, beat_cnt[0]=8.
//   - Mid-packet reset: assert resetn=0 after beat 2 of 4 -> all out_valid=0, FSM IDLE.
//     Next first beat re-samples in_sel.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types for stream_demux: FSM state encoding and statistics counter width.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFwd  = 2'd1,
    StDrop = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/stream_demux_slot.sv
// demux_slot: one-entry valid/ready output register for a single demux channel.
module demux_slot #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_fill,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  // Free when empty or draining this cycle, so fill and drain can overlap.
  assign o_free = !r_valid | i_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1-to-N packet demultiplexer; the first beat's in_sel steers the whole packet.
// Optional per-channel beat counters are enabled by defining STREAM_DEMUX_STATS_EN.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_OUT  = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_last,
`ifdef STREAM_DEMUX_STATS_EN
  output logic [N_OUT*CNT_W-1:0]  beat_cnt,
`endif
  output logic                    sel_err
);

  localparam logic [SEL_W:0] NOutW = (SEL_W+1)'(N_OUT);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [SEL_W-1:0] r_sel;
  logic             r_sel_err;
  logic [SEL_W-1:0] w_target;
  logic             w_sel_ok;
  logic             w_drop;
  logic             w_tgt_free;
  logic             w_fire;
  logic [N_OUT-1:0] w_fill;
  logic [N_OUT-1:0] w_free;

  assign w_sel_ok = {1'b0, in_sel} < NOutW;

  always_comb begin
    w_target    = r_sel;
    w_drop      = 1'b0;
    w_tgt_free  = 1'b0;
    w_fill      = '0;
    w_state_nxt = r_state;

    unique case (r_state)
      StIdle: begin
        w_target = in_sel;
        w_drop   = !w_sel_ok;
      end
      StFwd:   w_drop = 1'b0;
      StDrop:  w_drop = 1'b1;
      default: w_drop = 1'b1;
    endcase

    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (w_target == SEL_W'(i)) w_tgt_free = w_free[i];
    end

    // Dropped beats are always swallowed; forwarded beats wait for their slot only.
    in_ready = w_drop | w_tgt_free;
    w_fire   = in_valid & in_ready;

    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (w_fire && !w_drop && (w_target == SEL_W'(i))) w_fill[i] = 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (w_fire && !in_last) w_state_nxt = w_drop ? StDrop : StFwd;
      end
      StFwd, StDrop: begin
        if (w_fire && in_last) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= StIdle;
      r_sel     <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      if ((r_state == StIdle) && w_fire && !w_drop) r_sel <= in_sel;
      r_sel_err <= (r_state == StIdle) && in_valid && !w_sel_ok;
    end
  end

  assign sel_err = r_sel_err;

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk    (clk),
      .resetn (resetn),
      .i_fill (w_fill[g]),
      .i_data (in_data),
      .i_last (in_last),
      .i_ready(out_ready[g]),
      .o_valid(out_valid[g]),
      .o_data (out_data[g*DATA_W +: DATA_W]),
      .o_last (out_last[g]),
      .o_free (w_free[g])
    );
  end

`ifdef STREAM_DEMUX_STATS_EN
  for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        r_cnt <= '0;
      end else if (out_valid[g] && out_ready[g] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign beat_cnt[g*CNT_W +: CNT_W] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus randomized traffic
// checked against a per-channel queue model.
module tb_stream_demux;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_OUT  = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 16;

  logic                    clk;
  logic                    resetn;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    in_last;
  logic [SEL_W-1:0]        in_sel;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_last;
  logic                    sel_err;
`ifdef STREAM_DEMUX_STATS_EN
  logic [N_OUT*CNT_W-1:0]  beat_cnt;
`endif

  stream_demux #(
    .DATA_W(DATA_W),
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
`ifdef STREAM_DEMUX_STATS_EN
    .beat_cnt (beat_cnt),
`endif
    .sel_err  (sel_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          mon_en   = 1'b0;
  bit          rand_rdy = 1'b0;

  // Reference model: each channel holds the beats the spec says are waiting there.
  logic [DATA_W:0]  exp_q [N_OUT][$];
  bit               m_in_pkt = 1'b0;
  logic [SEL_W-1:0] m_sel    = '0;
  bit               m_drop   = 1'b0;
  bit               exp_err  = 1'b0;
  int unsigned      exp_cnt [N_OUT];

  initial for (int i = 0; i < N_OUT; i++) exp_cnt[i] = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [SEL_W-1:0] t;
      bit               drop;
      bit               exp_rdy;
      bit               nxt_err;
      t    = m_in_pkt ? m_sel : in_sel;
      drop = m_in_pkt ? m_drop : (int'(in_sel) >= N_OUT);
      exp_rdy = drop ? 1'b1 : ((exp_q[t].size() == 0) || out_ready[t]);
      for (int i = 0; i < N_OUT; i++) begin
        n_checks++;
        if (out_valid[i] !== (exp_q[i].size() != 0))
          $display("FAIL mon_valid ch%0d: got %b want %b", i, out_valid[i], exp_q[i].size() != 0);
        else n_pass++;
        if (exp_q[i].size() != 0) begin
          n_checks++;
          if ({out_last[i], out_data[i*DATA_W +: DATA_W]} !== exp_q[i][0])
            $display("FAIL mon_beat ch%0d: got %h want %h", i,
                     {out_last[i], out_data[i*DATA_W +: DATA_W]}, exp_q[i][0]);
          else n_pass++;
        end
`ifdef STREAM_DEMUX_STATS_EN
        n_checks++;
        if (beat_cnt[i*CNT_W +: CNT_W] !== CNT_W'(exp_cnt[i]))
          $display("FAIL mon_cnt ch%0d: got %0d want %0d", i, beat_cnt[i*CNT_W +: CNT_W], exp_cnt[i]);
        else n_pass++;
`endif
      end
      n_checks++;
      if (in_ready !== exp_rdy) $display("FAIL mon_in_ready: got %b want %b", in_ready, exp_rdy);
      else n_pass++;
      n_checks++;
      if (sel_err !== exp_err) $display("FAIL mon_sel_err: got %b want %b", sel_err, exp_err);
      else n_pass++;

      nxt_err = 1'b0;
      if (!resetn) begin
        for (int i = 0; i < N_OUT; i++) begin
          exp_q[i].delete();
          exp_cnt[i] = 0;
        end
        m_in_pkt = 1'b0;
      end else begin
        for (int i = 0; i < N_OUT; i++) begin
          if (exp_q[i].size() != 0 && out_ready[i]) begin
            void'(exp_q[i].pop_front());
            if (exp_cnt[i] < 65535) exp_cnt[i]++;
          end
        end
        if (in_valid && exp_rdy) begin
          if (!m_in_pkt) begin
            m_sel   = in_sel;
            m_drop  = int'(in_sel) >= N_OUT;
            nxt_err = m_drop;
          end
          if (!m_drop) exp_q[m_sel].push_back({in_last, in_data});
          m_in_pkt = !in_last;
        end
      end
      exp_err = nxt_err;
    end
  end

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic l, input logic [SEL_W-1:0] s,
                           output int unsigned cyc);
    bit acc;
    bit done;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_sel   = s;
    cyc      = 0;
    done     = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (rand_rdy) out_ready = N_OUT'($urandom);
      done = acc;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: got no accept want accept within 200 cycles");
    end
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = N_OUT'($urandom);
    end
  endtask

  task automatic apply_reset();
    resetn   = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    in_valid  = 1'b1;
    in_data   = $urandom;
    in_last   = 1'b0;
    in_sel    = 2'd0;
    out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== '0 || out_data !== '0 || out_last !== '0 || sel_err !== 1'b0)
      $display("FAIL reset_outputs: got v=%b d=%h l=%b e=%b want all zero",
               out_valid, out_data, out_last, sel_err);
    else n_pass++;
    resetn   = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== '0) $display("FAIL reset_no_consume: got %b want 000", out_valid);
    else n_pass++;
    mon_en = 1'b1;
  endtask

  task automatic test_routing();
    logic [DATA_W-1:0] beats [3];
    int unsigned cyc;
    beats[0]  = 32'hA1;
    beats[1]  = 32'hA2;
    beats[2]  = 32'hA3;
    out_ready = '1;
    for (int b = 0; b < 3; b++) begin
      send_beat(beats[b], b == 2, (b == 0) ? 2'd2 : 2'd0, cyc);
      n_checks++;
      if (out_valid !== 3'b100 || out_data[2*DATA_W +: DATA_W] !== beats[b] ||
          out_last[2] !== (b == 2))
        $display("FAIL routing_beat%0d: got v=%b d=%h l=%b want v=100 d=%h l=%b", b,
                 out_valid, out_data[2*DATA_W +: DATA_W], out_last[2], beats[b], b == 2);
      else n_pass++;
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] b1, b2, b3;
    int unsigned cyc;
    b1 = $urandom;
    b2 = $urandom;
    b3 = $urandom;
    out_ready = 3'b101;
    send_beat(b1, 1'b0, 2'd1, cyc);
    in_valid = 1'b1;
    in_data  = b2;
    in_sel   = 2'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid[1] !== 1'b1 || out_data[DATA_W +: DATA_W] !== b1)
        $display("FAIL bp_hold%0d: got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h", k,
                 in_ready, out_valid[1], out_data[DATA_W +: DATA_W], b1);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    out_ready = '1;
    send_beat(b2, 1'b0, 2'd0, cyc);
    n_checks++;
    if (out_data[DATA_W +: DATA_W] !== b2) $display("FAIL bp_release: got %h want %h",
                                                    out_data[DATA_W +: DATA_W], b2);
    else n_pass++;
    send_beat(b3, 1'b1, 2'd0, cyc);
    idle(2);
    n_checks++;
    if (out_valid !== '0) $display("FAIL bp_drained: got %b want 000", out_valid);
    else n_pass++;
  endtask

  task automatic test_invalid_sel();
    int unsigned cyc;
    logic [DATA_W-1:0] d3;
    out_ready = '1;
    send_beat($urandom, 1'b0, 2'd3, cyc);
    n_checks++;
    if (out_valid !== '0 || sel_err !== 1'b1)
      $display("FAIL badsel_first: got v=%b e=%b want v=000 e=1", out_valid, sel_err);
    else n_pass++;
    send_beat($urandom, 1'b1, 2'd0, cyc);
    n_checks++;
    if (out_valid !== '0 || sel_err !== 1'b0)
      $display("FAIL badsel_second: got v=%b e=%b want v=000 e=0", out_valid, sel_err);
    else n_pass++;
    d3 = $urandom;
    send_beat(d3, 1'b1, 2'd0, cyc);
    n_checks++;
    if (out_valid !== 3'b001 || out_data[0 +: DATA_W] !== d3)
      $display("FAIL badsel_recover: got v=%b d=%h want v=001 d=%h", out_valid,
               out_data[0 +: DATA_W], d3);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_back_to_back();
    int unsigned cyc;
    int unsigned total;
    logic [DATA_W-1:0] d;
    apply_reset();
    out_ready = '1;
    total     = 0;
    for (int b = 0; b < 8; b++) begin
      d = $urandom;
      send_beat(d, 1'b1, 2'd0, cyc);
      total += cyc;
      n_checks++;
      if (out_valid[0] !== 1'b1 || out_data[0 +: DATA_W] !== d)
        $display("FAIL b2b_beat%0d: got v=%b d=%h want v=1 d=%h", b, out_valid[0],
                 out_data[0 +: DATA_W], d);
      else n_pass++;
    end
    n_checks++;
    if (total !== 8) $display("FAIL b2b_cycles: got %0d want 8", total);
    else n_pass++;
    idle(1);
`ifdef STREAM_DEMUX_STATS_EN
    n_checks++;
    if (beat_cnt[0 +: CNT_W] !== 16'd8) $display("FAIL b2b_cnt: got %0d want 8", beat_cnt[0 +: CNT_W]);
    else n_pass++;
`endif
    idle(1);
  endtask

  task automatic test_mid_reset();
    int unsigned cyc;
    logic [DATA_W-1:0] d;
    out_ready = '1;
    send_beat($urandom, 1'b0, 2'd2, cyc);
    send_beat($urandom, 1'b0, 2'd0, cyc);
    out_ready = '0;
    idle(1);
    apply_reset();
    n_checks++;
    if (out_valid !== '0 || out_data !== '0)
      $display("FAIL midrst_clear: got v=%b d=%h want zero", out_valid, out_data);
    else n_pass++;
    out_ready = '1;
    d = $urandom;
    send_beat(d, 1'b1, 2'd1, cyc);
    n_checks++;
    if (out_valid !== 3'b010 || out_data[DATA_W +: DATA_W] !== d)
      $display("FAIL midrst_resample: got v=%b d=%h want v=010 d=%h", out_valid,
               out_data[DATA_W +: DATA_W], d);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_random();
    int unsigned cyc;
    int unsigned len;
    rand_rdy = 1'b1;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        send_beat($urandom, b == len - 1, SEL_W'($urandom_range(0, 3)), cyc);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    rand_rdy  = 1'b0;
    out_ready = '1;
    idle(3);
    n_checks++;
    if (out_valid !== '0) $display("FAIL rand_drained: got %b want 000", out_valid);
    else n_pass++;
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_sel    = '0;
    out_ready = '0;
    test_reset();
    test_routing();
    test_backpressure();
    test_invalid_sel();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
